// File: rtl/prt_slot_scheduler.sv
// rtl/prt_slot_scheduler.sv - PRT slot tag allocator, completion-order TX queue and single-issue TX FSM
// Optional PRT_SCHED_STATS_EN adds saturating stat_tx_frames / stat_drops counters.
module prt_slot_scheduler #(
    parameter int PRT_SIZE = 32,
    parameter int CNT_W    = $clog2(PRT_SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [5:0]       alloc_tag,
    input  logic             rx_done_valid,
    input  logic [5:0]       rx_done_tag,
    input  logic             rx_done_safe,
    input  logic             tx_ready,
    output logic             tx_start,
    output logic [5:0]       tx_tag,
    input  logic             tx_done,
    output logic [CNT_W-1:0] free_count,
    output logic             txq_empty,
    output logic             proto_err
`ifdef PRT_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_tx_frames,
    output logic [31:0]      stat_drops
`endif
);
    localparam int IDX_W = $clog2(PRT_SIZE);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t              state;
    logic [PRT_SIZE-1:0] free_map;
    logic [PRT_SIZE-1:0] next_map;
    logic [CNT_W-1:0]    next_cnt;
    logic [5:0]          q_mem [PRT_SIZE];
    logic [IDX_W-1:0]    q_head;
    logic [IDX_W-1:0]    q_tail;
    logic [CNT_W-1:0]    q_cnt;
    logic                rx_in_range;
    logic                rx_legal;
    logic                push;
    logic                drop;
    logic                pop;
    logic                done_ok;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(PRT_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // An rx_done is only meaningful for a slot that is currently owned by RX.
    assign rx_in_range = ({1'b0, rx_done_tag} < 7'(PRT_SIZE));
    assign rx_legal    = rx_done_valid && rx_in_range && !free_map[rx_done_tag[IDX_W-1:0]];
    assign push        = rx_legal && rx_done_safe;
    assign drop        = rx_legal && !rx_done_safe;
    assign pop         = (state == ISSUE);
    assign done_ok     = tx_done && (state == BUSY);
    assign alloc_gnt   = alloc_req && (free_count != '0);
    assign txq_empty   = (q_cnt == '0);

    always_comb begin
        alloc_tag = '0;
        for (int i = PRT_SIZE - 1; i >= 0; i--) begin
            if (free_map[i]) alloc_tag = 6'(i);
        end
    end

    // Freed slots land in the bitmap at the edge, so they are never granted in the freeing cycle.
    always_comb begin
        next_map = free_map;
        if (alloc_gnt) next_map[alloc_tag[IDX_W-1:0]] = 1'b0;
        if (drop)      next_map[rx_done_tag[IDX_W-1:0]] = 1'b1;
        if (done_ok)   next_map[tx_tag[IDX_W-1:0]] = 1'b1;
        next_cnt = '0;
        for (int i = 0; i < PRT_SIZE; i++) begin
            next_cnt = next_cnt + CNT_W'(next_map[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[q_tail] <= rx_done_tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_map   <= '1;
            free_count <= CNT_W'(PRT_SIZE);
            q_head     <= '0;
            q_tail     <= '0;
            q_cnt      <= '0;
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_tag     <= '0;
            proto_err  <= 1'b0;
        end else begin
            free_map   <= next_map;
            free_count <= next_cnt;
            if (push) q_tail <= wrap_inc(q_tail);
            if (pop)  q_head <= wrap_inc(q_head);
            unique case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: ;
            endcase
            if ((rx_done_valid && !rx_legal) || (tx_done && state != BUSY)) proto_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (q_cnt != '0 && tx_ready) begin
                        tx_tag   <= q_mem[q_head];
                        tx_start <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_start <= 1'b0;
                    state    <= BUSY;
                end
                BUSY: begin
                    if (tx_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_tx_frames <= '0;
            stat_drops     <= '0;
        end else begin
            if (done_ok && stat_tx_frames != '1) stat_tx_frames <= stat_tx_frames + 1'b1;
            if (drop && stat_drops != '1)        stat_drops     <= stat_drops + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_prt_slot_scheduler.sv
// tb/tb_prt_slot_scheduler.sv - scoreboard bench for prt_slot_scheduler
module tb_prt_slot_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [5:0] alloc_tag;
    logic       rx_done_valid = 1'b0;
    logic [5:0] rx_done_tag = '0;
    logic       rx_done_safe = 1'b0;
    logic       tx_ready = 1'b0;
    logic       tx_start;
    logic [5:0] tx_tag;
    logic       tx_done = 1'b0;
    logic [5:0] free_count;
    logic       txq_empty;
    logic       proto_err;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [5:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prt_slot_scheduler #(.PRT_SIZE(32)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .rx_done_valid(rx_done_valid), .rx_done_tag(rx_done_tag), .rx_done_safe(rx_done_safe),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_tag(tx_tag), .tx_done(tx_done),
        .free_count(free_count), .txq_empty(txq_empty), .proto_err(proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_start(input string tag);
        logic [5:0] e;
        check({tag, "_start"}, tx_start, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_tag"}, tx_tag, e);
        end
    endtask

    task automatic wait_start(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_timeout"}, 0, 1);
        else take_start(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alloc_req = 1'b0;
        rx_done_valid = 1'b0;
        tx_done = 1'b0;
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic alloc_n(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            #1;
            check("alloc_gnt", alloc_gnt, 1);
            check("alloc_tag", alloc_tag, first + i);
            tick();
        end
        alloc_req = 1'b0;
    endtask

    task automatic rx(input logic [5:0] tag, input logic safe, input logic expect_push);
        rx_done_valid = 1'b1;
        rx_done_tag = tag;
        rx_done_safe = safe;
        if (expect_push) sb.push_back(tag);
        tick();
        rx_done_valid = 1'b0;
    endtask

    int s_prev;
    int s_now;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state and full allocation sweep
        do_reset();
        check("rst_free_count", free_count, 32);
        check("rst_txq_empty", txq_empty, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_tag", tx_tag, 0);
        check("rst_proto_err", proto_err, 0);
        alloc_n(32, 0);
        check("full_free_count", free_count, 0);
        alloc_req = 1'b1;
        #1;
        check("full_gnt33", alloc_gnt, 0);
        alloc_req = 1'b0;

        // tx_done freeing a slot while full: not grantable in the same cycle
        tx_ready = 1'b1;
        rx(7, 1'b1, 1'b1);
        check("lat_no_start_yet", tx_start, 0);
        tick();
        take_start("lat7");
        tick();
        tx_done = 1'b1;
        alloc_req = 1'b1;
        #1;
        check("free_same_cycle_gnt", alloc_gnt, 0);
        tick();
        tx_done = 1'b0;
        #1;
        check("free_next_gnt", alloc_gnt, 1);
        check("free_next_tag", alloc_tag, 7);
        check("free_next_count", free_count, 1);
        tick();
        alloc_req = 1'b0;
        check("regrant_count", free_count, 0);
        check("regrant_proto", proto_err, 0);

        // completion-order TX with 3-cycle start spacing
        do_reset();
        tx_ready = 1'b0;
        alloc_n(6, 0);
        rx(5, 1'b1, 1'b1);
        rx(3, 1'b1, 1'b1);
        rx(4, 1'b1, 1'b1);
        check("order_txq_nonempty", txq_empty, 0);
        tx_ready = 1'b1;
        s_prev = -1;
        for (int k = 0; k < 3; k++) begin
            wait_start("order", s_now);
            if (s_prev >= 0) check("order_spacing", s_now - s_prev, 3);
            s_prev = s_now;
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        tick();
        check("order_free_count", free_count, 29);
        check("order_txq_empty", txq_empty, 1);
        check("order_sb_drained", sb.size(), 0);

        // unsafe drop returns slot without queuing
        do_reset();
        alloc_n(1, 0);
        check("drop_pre_count", free_count, 31);
        rx(0, 1'b0, 1'b0);
        check("drop_free_count", free_count, 32);
        check("drop_txq_empty", txq_empty, 1);
        alloc_req = 1'b1;
        #1;
        check("drop_regrant_tag", alloc_tag, 0);
        check("drop_regrant_gnt", alloc_gnt, 1);
        alloc_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drop_no_start", tx_start, 0);
        end
        #1;

        // protocol errors are ignored and sticky
        do_reset();
        rx(10, 1'b1, 1'b0);
        check("perr_free_tag", proto_err, 1);
        check("perr_free_count", free_count, 32);
        check("perr_txq_empty", txq_empty, 1);
        tick();
        tick();
        check("perr_sticky", proto_err, 1);
        do_reset();
        check("perr_cleared", proto_err, 0);
        rx(40, 1'b1, 1'b0);
        check("perr_range", proto_err, 1);
        check("perr_range_txq", txq_empty, 1);
        do_reset();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("perr_idle_done", proto_err, 1);
        check("perr_idle_count", free_count, 32);

        // reset while BUSY with five tags still queued
        do_reset();
        tx_ready = 1'b0;
        alloc_n(6, 0);
        for (int t = 0; t < 6; t++) rx(6'(t), 1'b1, 1'b1);
        tx_ready = 1'b1;
        wait_start("busy_rst", s_now);
        tick();
        check("busy_txq_nonempty", txq_empty, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("mid_rst_free_count", free_count, 32);
        check("mid_rst_txq_empty", txq_empty, 1);
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_tag", tx_tag, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_no_start", tx_start, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
